// File: rtl/trap_ctrl_if.sv
// Retirement/trap-report bundle between the core, trap_ctrl and the trap monitor.
interface trap_ctrl_if;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] a0;
  logic        overflow;
  logic        ack;
  logic        halt;
  logic        trap_valid;
  logic        program_finished;
  logic [2:0]  trap_code;
  logic [31:0] trap_pc;
  logic [31:0] trap_inst;
  logic [31:0] cycle_count;

  modport master (
    output valid, pc, instruction, a0, overflow, ack,
    input  halt, trap_valid, program_finished, trap_code, trap_pc, trap_inst, cycle_count
  );

  modport slave (
    input  valid, pc, instruction, a0, overflow, ack,
    output halt, trap_valid, program_finished, trap_code, trap_pc, trap_inst, cycle_count
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap controller: detects ebreak/overflow/dead-loop/timeout, halts the core and reports once.
// Define TRAP_WATCHDOG_EN to enable the RUN-state watchdog (TIMEOUT trap).
module trap_ctrl #(
  parameter logic [31:0] WDOG_CYCLES  = 32'd1000000,
  parameter int unsigned STALL_LIMIT  = 16,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  localparam logic [31:0] EBREAK     = 32'h00100073;
  localparam logic [2:0]  CODE_NONE  = 3'd0;
  localparam logic [2:0]  CODE_GOOD  = 3'd1;
  localparam logic [2:0]  CODE_BAD   = 3'd2;
  localparam logic [2:0]  CODE_OVF   = 3'd3;
  localparam logic [2:0]  CODE_DEAD  = 3'd4;
  localparam logic [2:0]  CODE_TMO   = 3'd5;
  localparam logic [15:0] STALL_MAX  = 16'(STALL_LIMIT);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

`ifdef TRAP_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, DRAIN, REPORT, HALTED} state_t;

  state_t      state;
  logic        halt_q;
  logic        trap_valid_q;
  logic        finished_q;
  logic [2:0]  code_q;
  logic [31:0] trap_pc_q;
  logic [31:0] trap_inst_q;
  logic [31:0] cycle_q;
  logic [15:0] stall_cnt;
  logic [31:0] prev_pc;
  logic        have_prev;
  logic [15:0] drain_cnt;

  logic        is_ebreak;
  logic        is_ovf;
  logic        same_pc;
  logic        is_dead;
  logic        is_tmo;
  logic [15:0] stall_next;
  logic [2:0]  trap_sel;

  // Trap sources resolved by priority: ebreak > overflow > dead-loop > timeout.
  always_comb begin
    is_ebreak  = bus.valid && (bus.instruction == EBREAK);
    is_ovf     = bus.valid && bus.overflow;
    same_pc    = bus.valid && have_prev && (bus.pc == prev_pc);
    stall_next = same_pc ? stall_cnt + 16'd1 : 16'd0;
    is_dead    = same_pc && (stall_next == STALL_MAX);
    is_tmo     = WDOG_EN && (cycle_q == WDOG_CYCLES - 32'd1);
    trap_sel   = CODE_NONE;
    if (is_ebreak)
      trap_sel = (bus.a0 == 32'd0) ? CODE_GOOD : CODE_BAD;
    else if (is_ovf)
      trap_sel = CODE_OVF;
    else if (is_dead)
      trap_sel = CODE_DEAD;
    else if (is_tmo)
      trap_sel = CODE_TMO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      halt_q       <= 1'b0;
      trap_valid_q <= 1'b0;
      finished_q   <= 1'b0;
      code_q       <= CODE_NONE;
      trap_pc_q    <= 32'd0;
      trap_inst_q  <= 32'd0;
      cycle_q      <= 32'd0;
      stall_cnt    <= 16'd0;
      prev_pc      <= 32'd0;
      have_prev    <= 1'b0;
      drain_cnt    <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (cycle_q != 32'hFFFF_FFFF)
            cycle_q <= cycle_q + 32'd1;
          if (bus.valid) begin
            prev_pc   <= bus.pc;
            have_prev <= 1'b1;
            stall_cnt <= stall_next;
          end
          if (trap_sel != CODE_NONE) begin
            code_q      <= trap_sel;
            trap_pc_q   <= bus.pc;
            trap_inst_q <= bus.instruction;
            halt_q      <= 1'b1;
            drain_cnt   <= 16'd0;
            // A zero-length drain goes straight to the report.
            if (DRAIN_CYCLES == 0) begin
              state        <= REPORT;
              trap_valid_q <= 1'b1;
              finished_q   <= (trap_sel == CODE_GOOD);
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state        <= REPORT;
            trap_valid_q <= 1'b1;
            finished_q   <= (code_q == CODE_GOOD);
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        REPORT: begin
          if (bus.ack) begin
            state        <= HALTED;
            trap_valid_q <= 1'b0;
            finished_q   <= 1'b0;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.halt             = halt_q;
  assign bus.trap_valid       = trap_valid_q;
  assign bus.program_finished = finished_q;
  assign bus.trap_code        = code_q;
  assign bus.trap_pc          = trap_pc_q;
  assign bus.trap_inst        = trap_inst_q;
  assign bus.cycle_count      = cycle_q;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter WDOG_CYCLES, 32'd1000000, RUN-state cycle limit before TIMEOUT trap.
REQ-002 Parameter STALL_LIMIT, 16, consecutive same-PC retirements that raise DEADLOOP.
REQ-003 Parameter DRAIN_CYCLES, 2, cycles between trap capture and report.
REQ-004 clk  input  1  the only clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 valid  input  1  one instruction retires this cycle.
REQ-007 pc  input  32  PC of the retiring instruction.
REQ-008 instruction  input  32  encoding of the retiring instruction.
REQ-009 a0  input  32  current value of x10; this is the program exit code.
REQ-010 overflow  input  1  ALU overflow for the retiring instruction.
REQ-011 ack  input  1  monitor has consumed the trap report.
REQ-012 halt  output  1  freeze PC/regfile writes in the core.
REQ-013 trap_valid  output  1  trap report presented.
REQ-014 program_finished  output  1  good-trap indication to the trap monitor.
REQ-015 trap_code  output  3  0 NONE, 1 GOOD, 2 BAD_EXIT, 3 OVERFLOW, 4 DEADLOOP, 5 TIMEOUT.
REQ-016 trap_pc / trap_inst  output  32 each  captured PC and instruction of the trapping retirement.
REQ-017 cycle_count  output  32  cycles spent in RUN, saturating at 32'hFFFFFFFF.

Function
REQ-018 The FSM SHALL have states RUN, DRAIN, REPORT and HALTED; RUN is the reset state.
REQ-019 In RUN, valid with instruction==32'h00100073 (ebreak) SHALL capture trap_pc/trap_inst and set code GOOD if a0==0, else BAD_EXIT.
REQ-020 In RUN, valid with overflow=1 SHALL capture and set code OVERFLOW.
REQ-021 The stall counter SHALL increment on valid with pc equal to the previous retired PC and clear on valid with a different PC; the first retirement after reset SHALL NOT be compared.
REQ-022 DEADLOOP SHALL fire on the valid retirement at which the stall counter reaches STALL_LIMIT.
REQ-023 Simultaneous trap sources SHALL resolve with priority ebreak > overflow > DEADLOOP > TIMEOUT; only one capture occurs.
REQ-024 Any capture SHALL move RUN->DRAIN and assert halt from the next cycle; halt SHALL stay 1 until reset.
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles, ignoring valid/overflow, then enter REPORT.
REQ-026 In REPORT, trap_valid SHALL be 1 and program_finished SHALL equal (trap_code==GOOD); both SHALL hold until ack=1.
REQ-027 ack=1 in REPORT SHALL move to HALTED on the next edge; ack outside REPORT SHALL be ignored.
REQ-028 In HALTED, trap_valid and program_finished SHALL be 0; trap_code/trap_pc/trap_inst SHALL retain their values.
REQ-029 cycle_count SHALL increment every RUN cycle and freeze on leaving RUN.

Reset
REQ-030 rst=1 at a clock edge SHALL force state RUN and set halt, trap_valid, program_finished, trap_code, trap_pc, trap_inst, cycle_count and the stall counter to 0, from any state.
REQ-031 Reset SHALL take priority over a simultaneous trap or ack.

Configuration
REQ-032 With TRAP_WATCHDOG_EN defined, the block SHALL raise TIMEOUT when cycle_count reaches WDOG_CYCLES in RUN.
REQ-033 Without TRAP_WATCHDOG_EN, TIMEOUT SHALL never be produced; cycle_count SHALL still count.

Verification
REQ-034 Retire pc=0x80000000..0x8000000C, then ebreak at 0x80000010 with a0=0 -> halt after 1 cycle, REPORT 2 cycles later, trap_code=1, program_finished=1, trap_pc=0x80000010.
REQ-035 Ebreak with a0=3 -> trap_code=2, program_finished=0, trap_valid held until ack, then HALTED.
REQ-036 Retire pc=0x80000020 17 times consecutively -> DEADLOOP (code 4) on the 17th retirement; the 16th does not trap.
REQ-037 Ebreak with overflow=1 in the same cycle -> code from ebreak only (1 or 2).
REQ-038 TRAP_WATCHDOG_EN, WDOG_CYCLES=100, no valid -> code 5 at cycle_count=100; without the macro, no trap after 200 cycles.
REQ-039 rst=1 during REPORT with ack=1 -> next cycle state RUN, all outputs 0.
